// File: rtl/mitch_trunc_div.sv
// Multi-cycle Mitchell log-domain approximate divider with W-bit truncated mantissas.
// One operation in flight: IDLE -> LOD -> LOGSUB -> SHIFT -> DONE, valid/ready on both sides.
module mitch_trunc_div #(
   parameter int XW = 32,
   parameter int YW = 16,
   parameter int QW = 16,
   parameter int W  = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] q,
   output logic          ovf,
   output logic          dz
);

   localparam int KXW = $clog2(XW);
   localparam int KYW = $clog2(YW);
   localparam int EW  = 7;
   localparam int SW  = QW + W + 1;

   typedef enum logic [2:0] {IDLE, LOD, LOGSUB, SHIFT, DONE} state_t;

   state_t state, state_nx;

   logic [XW-1:0]         x_r;
   logic [YW-1:0]         y_r;
   logic [KXW-1:0]        k1_r;
   logic [KYW-1:0]        k2_r;
   logic [W-1:0]          f1_r, f2_r;
   logic                  xz_r, yz_r;
   logic [W:0]            m_r;
   logic signed [EW-1:0]  e_r;
   logic                  sp_dz_r, sp_zero_r;

   function automatic logic [KXW-1:0] lod_x(input logic [XW-1:0] v);
      lod_x = '0;
      for (int i = 0; i < XW; i++)
         if (v[i]) lod_x = KXW'(i);
   endfunction

   function automatic logic [KYW-1:0] lod_y(input logic [YW-1:0] v);
      lod_y = '0;
      for (int i = 0; i < YW; i++)
         if (v[i]) lod_y = KYW'(i);
   endfunction

   // LOD: normalise so the leading one sits at the MSB; bits below it (zero-padded) are the mantissa
   logic [KXW-1:0] k1_c;
   logic [KYW-1:0] k2_c;
   logic [XW-1:0]  xn_c;
   logic [YW-1:0]  yn_c;

   always_comb begin
      k1_c = lod_x(x_r);
      k2_c = lod_y(y_r);
      xn_c = x_r << (KXW'(XW - 1) - k1_c);
      yn_c = y_r << (KYW'(YW - 1) - k2_c);
   end

   // LOGSUB: 2^W+f1-f2 and f1-f2 agree modulo 2^W, so one W-bit subtract covers both cases
   logic [W-1:0]         d_c;
   logic signed [EW-1:0] e_c;

   always_comb begin
      d_c = f1_r - f2_r;
      e_c = $signed(EW'(k1_r)) - $signed(EW'(k2_r)) - $signed(EW'(f1_r < f2_r));
   end

   // SHIFT: antilog; right shift floors, shifting everything out gives zero
   logic [SW-1:0]  sh_c;
   logic [EW-1:0]  lsh_c, rsh_c;
   logic [QW-1:0]  q_c;
   logic           ovf_c;

   always_comb begin
      lsh_c = e_r - EW'(W);
      rsh_c = EW'(W) - e_r;
      if (e_r >= $signed(EW'(W))) sh_c = SW'(m_r) << lsh_c;
      else                        sh_c = SW'(m_r) >> rsh_c;
      q_c   = sh_c[QW-1:0];
      ovf_c = 1'b0;
      if (sp_dz_r) begin
         q_c = '1;
      end else if (sp_zero_r) begin
         q_c = '0;
      end else if (e_r >= $signed(EW'(QW))) begin
         q_c   = '1;
         ovf_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = LOD;
         end
         LOD:    state_nx = LOGSUB;
         LOGSUB: state_nx = SHIFT;
         SHIFT:  state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r       <= '0;
         y_r       <= '0;
         k1_r      <= '0;
         k2_r      <= '0;
         f1_r      <= '0;
         f2_r      <= '0;
         xz_r      <= 1'b0;
         yz_r      <= 1'b0;
         m_r       <= '0;
         e_r       <= '0;
         sp_dz_r   <= 1'b0;
         sp_zero_r <= 1'b0;
         q         <= '0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               x_r <= x;
               y_r <= y;
            end
            LOD: begin
               k1_r <= k1_c;
               k2_r <= k2_c;
               f1_r <= xn_c[XW-2 -: W];
               f2_r <= yn_c[YW-2 -: W];
               xz_r <= (x_r == '0);
               yz_r <= (y_r == '0);
            end
            LOGSUB: begin
               m_r       <= {1'b1, d_c};
               e_r       <= e_c;
               sp_dz_r   <= yz_r;
               sp_zero_r <= xz_r & ~yz_r;
            end
            SHIFT: begin
               q   <= q_c;
               ovf <= ovf_c;
               dz  <= sp_dz_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mitch_trunc_div.sv
// Directed bench for mitch_trunc_div: hand-computed Mitchell quotients, handshake and reset behaviour.
module tb_mitch_trunc_div;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] x = '0;
   logic [15:0] y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] q;
   logic        ovf;
   logic        dz;

   int checks = 0;
   int failures = 0;

   mitch_trunc_div dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
      .q(q), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;

   // Issue one operation; lat counts edges from the handshake edge (inclusive) to out_valid.
   // The result is left pending in DONE; the caller decides when to consume it.
   task automatic issue(input logic [31:0] xv, input logic [15:0] yv, output int lat);
      @(negedge clk);
      x = xv; y = yv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'h0 || ovf !== 1'b0 || dz !== 1'b0) begin
         failures++;
         $display("FAIL reset: in_ready=%b out_valid=%b q=%h ovf=%b dz=%b, want 1 0 0000 0 0",
                  in_ready, out_valid, q, ovf, dz);
      end
   endtask

   task automatic test_basic;
      int lat;
      issue(32'd100, 16'd10, lat);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL basic_latency: got %0d want 4", lat); end
      checks++;
      if (q !== 16'd10 || ovf !== 1'b0 || dz !== 1'b0) begin
         failures++; $display("FAIL basic_100_10: q=%0d ovf=%b dz=%b want 10 0 0", q, ovf, dz);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL basic_return: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_mitchell;
      int lat;
      // 1000: k1=9 f1=30; 3: k2=1 f2=16; d=14 e=8 -> 46<<3
      issue(32'd1000, 16'd3, lat);
      checks++;
      if (q !== 16'd368 || ovf !== 1'b0) begin
         failures++; $display("FAIL mitchell_1000_3: q=%0d ovf=%b want 368 0", q, ovf);
      end
      consume();
      // 1/3: f1<f2 so e=-2, m=48 >> 7
      issue(32'd1, 16'd3, lat);
      checks++;
      if (q !== 16'd0 || ovf !== 1'b0 || dz !== 1'b0) begin
         failures++; $display("FAIL mitchell_1_3: q=%0d ovf=%b dz=%b want 0 0 0", q, ovf, dz);
      end
      consume();
      // 255/16: k1=7 f1=31; k2=4 f2=0; e=3 m=63 >> 2
      issue(32'd255, 16'd16, lat);
      checks++;
      if (q !== 16'd15) begin failures++; $display("FAIL mitchell_255_16: q=%0d want 15", q); end
      consume();
   endtask

   task automatic test_special;
      int lat;
      issue(32'h12345678, 16'd0, lat);
      checks++;
      if (lat !== 4) begin failures++; $display("FAIL dz_latency: got %0d want 4", lat); end
      checks++;
      if (q !== 16'hFFFF || dz !== 1'b1 || ovf !== 1'b0) begin
         failures++; $display("FAIL div_zero: q=%h dz=%b ovf=%b want ffff 1 0", q, dz, ovf);
      end
      consume();
      issue(32'd0, 16'd7, lat);
      checks++;
      if (q !== 16'd0 || dz !== 1'b0 || ovf !== 1'b0) begin
         failures++; $display("FAIL zero_dividend: q=%h dz=%b ovf=%b want 0000 0 0", q, dz, ovf);
      end
      consume();
   endtask

   task automatic test_saturation;
      int lat;
      issue(32'hFFFFFFFF, 16'd1, lat);
      checks++;
      if (q !== 16'hFFFF || ovf !== 1'b1 || dz !== 1'b0) begin
         failures++; $display("FAIL sat_e31: q=%h ovf=%b dz=%b want ffff 1 0", q, ovf, dz);
      end
      consume();
      // e=15 just under QW: m=63 << 10, mantissa truncated to 5 bits
      issue(32'h0000FFFF, 16'd1, lat);
      checks++;
      if (q !== 16'hFC00 || ovf !== 1'b0) begin
         failures++; $display("FAIL edge_e15: q=%h ovf=%b want fc00 0", q, ovf);
      end
      consume();
      // e=16 exactly: 0x10000/1 saturates
      issue(32'h00010000, 16'd1, lat);
      checks++;
      if (q !== 16'hFFFF || ovf !== 1'b1) begin
         failures++; $display("FAIL edge_e16: q=%h ovf=%b want ffff 1", q, ovf);
      end
      consume();
   endtask

   task automatic test_backpressure;
      int lat;
      int extra;
      out_ready = 1'b0;
      issue(32'd1000, 16'd3, lat);
      @(negedge clk);
      x = 32'd100; y = 16'd10; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (q !== 16'd368 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_hold%0d: q=%0d in_ready=%b out_valid=%b want 368 0 1",
                     i, q, in_ready, out_valid);
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      checks++;
      if (extra !== 0) begin failures++; $display("FAIL backpressure_single: extra valid cycles=%0d want 0", extra); end
   endtask

   task automatic test_back_to_back;
      int gap;
      int seen;
      @(negedge clk);
      x = 32'd100; y = 16'd10; in_valid = 1'b1;
      gap = 0; seen = 0;
      // count edges between successive input handshakes with in_valid and out_ready held high
      for (int i = 0; i < 12 && seen < 2; i++) begin
         @(negedge clk);
         if (in_ready && in_valid) begin
            if (seen == 1) seen = 2;
            else seen = 1;
         end
         if (seen == 1) gap++;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (seen !== 2 || gap !== 5) begin
         failures++; $display("FAIL back_to_back_interval: seen=%0d gap=%0d want 2 5", seen, gap);
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_abort;
      int lat;
      @(negedge clk);
      x = 32'd100; y = 16'd10; in_valid = 1'b1;
      @(posedge clk); #1;     // handshake -> LOD
      in_valid = 1'b0;
      @(posedge clk); #1;     // LOGSUB
      @(posedge clk); #1;     // SHIFT
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || q !== 16'h0 || ovf !== 1'b0 || dz !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort: out_valid=%b in_ready=%b q=%h ovf=%b dz=%b want 0 1 0000 0 0",
                  out_valid, in_ready, q, ovf, dz);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(32'd100, 16'd10, lat);
      checks++;
      if (lat !== 4 || q !== 16'd10) begin
         failures++; $display("FAIL after_abort: q=%0d lat=%0d want 10 4", q, lat);
      end
      consume();
   endtask

   initial begin
      #1;
      test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_mitchell();
      test_special();
      test_saturation();
      test_backpressure();
      test_back_to_back();
      // q now holds 10 from the back-to-back run, so the abort check sees a real clear
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want completion");
      $fatal(1);
   end

endmodule
